// File: rtl/rv_dep_scard_mt.sv
// Dependency scoreboard tracking outstanding itags: per-slot busy/wrap state with
// allocate, complete/abort, full and partial flush, and combinational source lookups.
module rv_dep_scard_mt #(
  parameter int NUM_ENTRIES = 32,
  parameter int ITAG_W      = 6,
  parameter int NUM_SET     = 2,
  parameter int NUM_CLR     = 7,
  parameter int NUM_LKP     = 6,
  parameter int BYPASS      = 1
) (
  input  logic                        nclk,
  input  logic                        rst,
  input  logic                        act,
  input  logic [NUM_SET-1:0]          set_v,
  input  logic [NUM_SET*ITAG_W-1:0]   set_itag,
  input  logic [NUM_CLR-1:0]          clr_v,
  input  logic [NUM_CLR-1:0]          clr_abort,
  input  logic [NUM_CLR*ITAG_W-1:0]   clr_itag,
  input  logic                        zap,
  input  logic                        flush_v,
  input  logic [ITAG_W-1:0]           flush_itag,
  input  logic [NUM_LKP*ITAG_W-1:0]   lkp_itag,
  output logic [NUM_LKP-1:0]          lkp_busy,
  output logic [$clog2(NUM_ENTRIES):0] busy_cnt,
  output logic                        empty,
  output logic                        err_dup
);

  localparam int IDX_W = ITAG_W - 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic [NUM_ENTRIES-1:0] busy_q, wrap_q, busy_n, wrap_n;
  logic [NUM_ENTRIES-1:0] set_hit, set_wrap, abort_hit, comp_hit, flush_hit;
  logic                   dup;
  logic [CNT_W-1:0]       cnt_n;

  // Circular age compare: slot is at or after the flush point in program order.
  function automatic logic younger(input logic w, input logic [IDX_W-1:0] idx,
                                   input logic [ITAG_W-1:0] f);
    younger = ((w == f[ITAG_W-1]) && (idx >= f[IDX_W-1:0])) ||
              ((w != f[ITAG_W-1]) && (idx <  f[IDX_W-1:0]));
  endfunction

  always_comb begin
    logic [ITAG_W-1:0] t;
    logic [ITAG_W-1:0] u;
    t = '0;
    u = '0;
    set_hit   = '0;
    set_wrap  = '0;
    abort_hit = '0;
    comp_hit  = '0;
    flush_hit = '0;
    dup       = 1'b0;
    // Iterate downwards so port 0 owns the wrap bit when ports collide.
    for (int p = NUM_SET - 1; p >= 0; p--) begin
      t = set_itag[(NUM_SET-1-p)*ITAG_W +: ITAG_W];
      if (set_v[p]) begin
        set_hit[t[IDX_W-1:0]]  = 1'b1;
        set_wrap[t[IDX_W-1:0]] = t[ITAG_W-1];
      end
    end
    for (int c = 0; c < NUM_CLR; c++) begin
      t = clr_itag[(NUM_CLR-1-c)*ITAG_W +: ITAG_W];
      if (clr_v[c] && !clr_abort[c] && (wrap_q[t[IDX_W-1:0]] == t[ITAG_W-1]))
        comp_hit[t[IDX_W-1:0]] = 1'b1;
      if (clr_v[c] && clr_abort[c])
        abort_hit[t[IDX_W-1:0]] = 1'b1;
    end
    for (int p = 0; p < NUM_SET; p++) begin
      t = set_itag[(NUM_SET-1-p)*ITAG_W +: ITAG_W];
      if (set_v[p] && busy_q[t[IDX_W-1:0]] && !comp_hit[t[IDX_W-1:0]])
        dup = 1'b1;
      for (int q = p + 1; q < NUM_SET; q++) begin
        u = set_itag[(NUM_SET-1-q)*ITAG_W +: ITAG_W];
        if (set_v[p] && set_v[q] && (t[IDX_W-1:0] == u[IDX_W-1:0]))
          dup = 1'b1;
      end
    end
    // A same-cycle allocation is judged by its own wrap bit so it flushes too.
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      flush_hit[i] = flush_v &&
        ((busy_q[i]  && younger(wrap_q[i],   IDX_W'(i), flush_itag)) ||
         (set_hit[i] && younger(set_wrap[i], IDX_W'(i), flush_itag)));
    end
  end

  always_comb begin
    busy_n = busy_q;
    wrap_n = wrap_q;
    cnt_n  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (zap || flush_hit[i] || comp_hit[i]) begin
        busy_n[i] = 1'b0;
      end else if (set_hit[i] || abort_hit[i]) begin
        busy_n[i] = 1'b1;
        if (set_hit[i])
          wrap_n[i] = set_wrap[i];
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++)
      cnt_n = cnt_n + CNT_W'(busy_n[i]);
  end

  always_comb begin
    logic [ITAG_W-1:0] t;
    t = '0;
    lkp_busy = '0;
    for (int k = 0; k < NUM_LKP; k++) begin
      t = lkp_itag[(NUM_LKP-1-k)*ITAG_W +: ITAG_W];
      lkp_busy[k] = busy_q[t[IDX_W-1:0]] && (wrap_q[t[IDX_W-1:0]] == t[ITAG_W-1]);
      if (BYPASS != 0) begin
        for (int c = 0; c < NUM_CLR; c++) begin
          if (clr_v[c] && !clr_abort[c] &&
              (clr_itag[(NUM_CLR-1-c)*ITAG_W +: ITAG_W] == t))
            lkp_busy[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge nclk) begin
    if (rst) begin
      busy_q   <= '0;
      wrap_q   <= '0;
      busy_cnt <= '0;
      empty    <= 1'b1;
      err_dup  <= 1'b0;
    end else if (act) begin
      busy_q   <= busy_n;
      wrap_q   <= wrap_n;
      busy_cnt <= cnt_n;
      empty    <= (cnt_n == '0);
      err_dup  <= err_dup | dup;
    end
  end

endmodule

// File: tb/tb_rv_dep_scard_mt.sv
// Self-checking bench for rv_dep_scard_mt: table-driven cycles plus hand sequences,
// registered outputs checked through an expectation queue.
module tb_rv_dep_scard_mt;

  logic        nclk = 1'b0;
  logic        rst, act, zap, flush_v;
  logic [1:0]  set_v;
  logic [11:0] set_itag;
  logic [6:0]  clr_v, clr_abort;
  logic [41:0] clr_itag;
  logic [5:0]  flush_itag;
  logic [35:0] lkp_itag;
  logic [5:0]  lkp_busy;
  logic [5:0]  busy_cnt;
  logic        empty, err_dup;

  typedef struct packed {
    logic        rst;
    logic        act;
    logic [1:0]  set_v;
    logic [11:0] set_itag;
    logic [6:0]  clr_v;
    logic [6:0]  clr_abort;
    logic [41:0] clr_itag;
    logic        zap;
    logic        flush_v;
    logic [5:0]  flush_itag;
    logic [35:0] lkp_itag;
    logic [5:0]  lkp_mask;
    logic [5:0]  lkp_exp;
    logic [5:0]  cnt;
    logic        empty;
    logic        err;
    logic        chk_err;
  } vec_t;

  typedef struct packed {
    int          tag;
    logic [5:0]  cnt;
    logic        empty;
    logic        err;
    logic        chk_err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[20];
  vec_t v;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tag      = 0;

  rv_dep_scard_mt dut (
    .nclk(nclk), .rst(rst), .act(act),
    .set_v(set_v), .set_itag(set_itag),
    .clr_v(clr_v), .clr_abort(clr_abort), .clr_itag(clr_itag),
    .zap(zap), .flush_v(flush_v), .flush_itag(flush_itag),
    .lkp_itag(lkp_itag), .lkp_busy(lkp_busy),
    .busy_cnt(busy_cnt), .empty(empty), .err_dup(err_dup)
  );

  always #5 nclk = ~nclk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t idle();
    vec_t r;
    r = '0;
    r.act = 1'b1;
    r.chk_err = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [1:0] sv, input logic [5:0] s0, input logic [5:0] s1,
                               input logic cv, input logic cab, input logic [5:0] ci,
                               input logic z, input logic fv, input logic [5:0] fi,
                               input logic [5:0] la, input logic [5:0] lb,
                               input logic ea, input logic eb,
                               input logic [5:0] ec, input logic ee, input logic er);
    vec_t r;
    r = idle();
    r.set_v      = sv;
    r.set_itag   = {s0, s1};
    r.clr_v      = {6'b0, cv};
    r.clr_abort  = {6'b0, cab};
    r.clr_itag   = {ci, 36'b0};
    r.zap        = z;
    r.flush_v    = fv;
    r.flush_itag = fi;
    r.lkp_itag   = {la, 24'b0, lb};
    r.lkp_mask   = 6'b100001;
    r.lkp_exp    = {eb, 4'b0, ea};
    r.cnt        = ec;
    r.empty      = ee;
    r.err        = er;
    return r;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: queue empty, got nothing expected entry");
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (busy_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL busy_cnt step %0d: got %0d expected %0d", e.tag, busy_cnt, e.cnt);
      end
      n_checks++;
      if (empty !== e.empty) begin
        n_fail++;
        $display("[TB] FAIL empty step %0d: got %b expected %b", e.tag, empty, e.empty);
      end
      if (e.chk_err) begin
        n_checks++;
        if (err_dup !== e.err) begin
          n_fail++;
          $display("[TB] FAIL err_dup step %0d: got %b expected %b", e.tag, err_dup, e.err);
        end
      end
    end
  endtask

  // Drive on the falling edge, check lookups just after, and the registered view after the rise.
  task automatic applyStimulus(input vec_t s);
    @(negedge nclk);
    rst        = s.rst;
    act        = s.act;
    set_v      = s.set_v;
    set_itag   = s.set_itag;
    clr_v      = s.clr_v;
    clr_abort  = s.clr_abort;
    clr_itag   = s.clr_itag;
    zap        = s.zap;
    flush_v    = s.flush_v;
    flush_itag = s.flush_itag;
    lkp_itag   = s.lkp_itag;
    #1;
    if (s.lkp_mask != 6'b0) begin
      n_checks++;
      if ((lkp_busy & s.lkp_mask) !== (s.lkp_exp & s.lkp_mask)) begin
        n_fail++;
        $display("[TB] FAIL lkp_busy step %0d: got %b expected %b (mask %b)",
                 tag, lkp_busy & s.lkp_mask, s.lkp_exp & s.lkp_mask, s.lkp_mask);
      end
    end
    exp_q.push_back('{tag: tag, cnt: s.cnt, empty: s.empty, err: s.err, chk_err: s.chk_err});
    @(posedge nclk);
    #1;
    checkOutput();
    tag++;
  endtask

  initial begin
    rst = 1'b1; act = 1'b0; set_v = '0; set_itag = '0; clr_v = '0; clr_abort = '0;
    clr_itag = '0; zap = 1'b0; flush_v = 1'b0; flush_itag = '0; lkp_itag = '0;

    vecs[0]  = mkv(2'b01, 6'h05, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h05, 6'h00, 0, 0, 6'd1, 0, 0);
    vecs[1]  = mkv(2'b00, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h05, 6'h00, 1, 0, 6'd1, 0, 0);
    vecs[2]  = mkv(2'b00, 6'h00, 6'h00, 1, 0, 6'h05, 0, 0, 6'h00, 6'h05, 6'h00, 0, 0, 6'd0, 1, 0);
    vecs[3]  = mkv(2'b10, 6'h00, 6'h21, 0, 0, 6'h00, 0, 0, 6'h00, 6'h21, 6'h00, 0, 0, 6'd1, 0, 0);
    vecs[4]  = mkv(2'b00, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h01, 6'h21, 0, 1, 6'd1, 0, 0);
    vecs[5]  = mkv(2'b00, 6'h00, 6'h00, 1, 0, 6'h01, 0, 0, 6'h00, 6'h21, 6'h00, 1, 0, 6'd1, 0, 0);
    vecs[6]  = mkv(2'b00, 6'h00, 6'h00, 1, 0, 6'h21, 0, 0, 6'h00, 6'h21, 6'h00, 0, 0, 6'd0, 1, 0);
    vecs[7]  = mkv(2'b11, 6'h1E, 6'h1F, 0, 0, 6'h00, 0, 0, 6'h00, 6'h1E, 6'h00, 0, 0, 6'd2, 0, 0);
    vecs[8]  = mkv(2'b11, 6'h20, 6'h21, 0, 0, 6'h00, 0, 0, 6'h00, 6'h1E, 6'h1F, 1, 1, 6'd4, 0, 0);
    vecs[9]  = mkv(2'b00, 6'h00, 6'h00, 0, 0, 6'h00, 0, 1, 6'h1F, 6'h20, 6'h1E, 1, 1, 6'd1, 0, 0);
    vecs[10] = mkv(2'b00, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h1E, 6'h1F, 1, 0, 6'd1, 0, 0);
    vecs[11] = mkv(2'b01, 6'h07, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 0, 0, 6'd2, 0, 0);
    vecs[12] = mkv(2'b00, 6'h00, 6'h00, 1, 1, 6'h07, 0, 0, 6'h00, 6'h07, 6'h00, 1, 0, 6'd2, 0, 0);
    vecs[13] = mkv(2'b00, 6'h00, 6'h00, 1, 1, 6'h09, 0, 0, 6'h00, 6'h09, 6'h00, 0, 0, 6'd3, 0, 0);
    vecs[14] = mkv(2'b00, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h09, 6'h07, 1, 1, 6'd3, 0, 0);
    vecs[15] = mkv(2'b01, 6'h03, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 0, 0, 6'd4, 0, 0);
    vecs[16] = mkv(2'b01, 6'h03, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h03, 6'h00, 1, 0, 6'd4, 0, 1);
    vecs[17] = mkv(2'b00, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h03, 6'h1E, 1, 1, 6'd4, 0, 1);
    vecs[18] = mkv(2'b01, 6'h0A, 6'h00, 0, 0, 6'h00, 0, 1, 6'h08, 6'h09, 6'h00, 1, 0, 6'd2, 0, 1);
    vecs[19] = mkv(2'b00, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0, 6'h00, 6'h0A, 6'h09, 0, 0, 6'd2, 0, 1);

    v = idle(); v.rst = 1'b1; v.empty = 1'b1;
    applyStimulus(v);
    applyStimulus(v);

    for (int i = 0; i < 20; i++)
      applyStimulus(vecs[i]);

    // act low: allocation and completion are both ignored; live slots are 3 and 7.
    v = idle(); v.act = 1'b0; v.set_v = 2'b01; v.set_itag = {6'd20, 6'd0};
    v.clr_v = 7'b0000001; v.clr_itag = {6'd7, 36'b0};
    v.lkp_itag = {6'd3, 30'b0}; v.lkp_mask = 6'b000001; v.lkp_exp = 6'b000001;
    v.cnt = 6'd2; v.err = 1'b1;
    applyStimulus(v);
    v = idle(); v.lkp_itag = {6'd20, 24'b0, 6'd7}; v.lkp_mask = 6'b100001; v.lkp_exp = 6'b100000;
    v.cnt = 6'd2; v.err = 1'b1;
    applyStimulus(v);

    // Reset mid-operation swallows a concurrent allocation.
    v = idle(); v.rst = 1'b1; v.set_v = 2'b01; v.set_itag = {6'd12, 6'd0};
    v.lkp_itag = {6'd3, 30'b0}; v.lkp_mask = 6'b000001; v.lkp_exp = 6'b000001;
    v.empty = 1'b1;
    applyStimulus(v);
    v = idle(); v.lkp_itag = {6'd12, 24'b0, 6'd3}; v.lkp_mask = 6'b100001; v.lkp_exp = 6'b000000;
    v.empty = 1'b1;
    applyStimulus(v);

    // Two ports allocating the same index in one cycle.
    v = idle(); v.set_v = 2'b11; v.set_itag = {6'h05, 6'h25}; v.cnt = 6'd1; v.err = 1'b1;
    applyStimulus(v);
    v = idle(); v.rst = 1'b1; v.empty = 1'b1;
    applyStimulus(v);

    // Bypass from the last clear port seen on middle lookup ports.
    v = idle(); v.set_v = 2'b10; v.set_itag = {6'h00, 6'h11}; v.cnt = 6'd1;
    applyStimulus(v);
    v = idle(); v.lkp_itag = {24'b0, 6'h11, 6'h00}; v.lkp_mask = 6'b010000; v.lkp_exp = 6'b010000;
    v.cnt = 6'd1;
    applyStimulus(v);
    v = idle(); v.clr_v = 7'b1000000; v.clr_itag = {36'b0, 6'h11};
    v.lkp_itag = {12'b0, 6'h11, 6'h11, 12'b0}; v.lkp_mask = 6'b011100; v.lkp_exp = 6'b000000;
    v.empty = 1'b1;
    applyStimulus(v);

    // Fill every slot, then zap while allocating slot 4.
    for (int k = 0; k < 16; k++) begin
      v = idle(); v.set_v = 2'b11; v.set_itag = {6'(2*k), 6'(2*k+1)}; v.cnt = 6'(2*k+2);
      applyStimulus(v);
    end
    v = idle(); v.zap = 1'b1; v.set_v = 2'b01; v.set_itag = {6'd4, 6'd0};
    v.lkp_itag = {6'd4, 30'b0}; v.lkp_mask = 6'b000001; v.lkp_exp = 6'b000001;
    v.empty = 1'b1; v.chk_err = 1'b0;
    applyStimulus(v);
    v = idle(); v.lkp_itag = {6'd4, 24'b0, 6'd31}; v.lkp_mask = 6'b100001; v.lkp_exp = 6'b000000;
    v.empty = 1'b1; v.chk_err = 1'b0;
    applyStimulus(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_dep_scard_mt.md
RV_DEP_SCARD_MT -- requirements
Module: rv_dep_scard_mt

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 32, meaning tracked itag slots; power of 2, 4..64.
REQ-002 SHALL have parameter ITAG_W, default 6, meaning itag width: log2(NUM_ENTRIES) index bits plus 1 wrap bit in the MSB.
REQ-003 SHALL have parameter NUM_SET, default 2, meaning allocation ports.
REQ-004 SHALL have parameter NUM_CLR, default 7, meaning completion/abort ports.
REQ-005 SHALL have parameter NUM_LKP, default 6, meaning source lookup ports.
REQ-006 SHALL have parameter BYPASS, default 1, meaning that a same-cycle non-abort clear hides the lookup hit.
REQ-007 SHALL have port nclk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-009 SHALL have port act, input, 1 bit: the state-update enable; when act=0, all state holds, except that rst still applies.
REQ-010 SHALL have port set_v, input, NUM_SET bits: allocation valid per port.
REQ-011 SHALL have port set_itag, input, NUM_SET*ITAG_W bits: allocation itag, with port 0 in the MSBs.
REQ-012 SHALL have port clr_v, input, NUM_CLR bits: completion valid per port.
REQ-013 SHALL have port clr_abort, input, NUM_CLR bits: the completion is an abort (slot is re-marked busy).
REQ-014 SHALL have port clr_itag, input, NUM_CLR*ITAG_W bits: completion itag.
REQ-015 SHALL have port zap, input, 1 bit: full flush.
REQ-016 SHALL have port flush_v, input, 1 bit: partial flush request.
REQ-017 SHALL have port flush_itag, input, ITAG_W bits: the oldest itag to flush.
REQ-018 SHALL have port lkp_itag, input, NUM_LKP*ITAG_W bits: source itags to look up.
REQ-019 SHALL have port lkp_busy, output, NUM_LKP bits: the source producer is still outstanding.
REQ-020 SHALL have port busy_cnt, output, log2(NUM_ENTRIES)+1 bits: registered count of busy slots.
REQ-021 SHALL have port empty, output, 1 bit: registered, busy_cnt==0.
REQ-022 SHALL have port err_dup, output, 1 bit: sticky flag for allocation of an already-busy slot.

Function
REQ-023 SHALL keep per-slot state: busy_q[NUM_ENTRIES] and wrap_q[NUM_ENTRIES]; slot index = itag low bits.
REQ-024 SHALL, on set_v[p], mark slot busy and load its wrap bit from set_itag[p] MSB.
REQ-025 SHALL, on clr_v[c]&~clr_abort[c] with matching index and wrap, clear the slot (completion).
REQ-026 SHALL, on clr_v[c]&clr_abort[c] with matching index, set the slot busy without changing its wrap bit.
REQ-027 SHALL apply this per-slot priority, highest first: rst, zap, partial flush, completion, abort/set, hold.
REQ-028 SHALL treat a busy slot as younger-or-equal to flush_itag when (wrap==fwrap & idx>=fidx) | (wrap!=fwrap & idx<fidx); flush_v SHALL clear exactly those slots, evaluated on busy_q and wrap_q.
REQ-029 SHALL let set and flush on the same slot in the same cycle resolve to flush (slot not busy).
REQ-030 SHALL make lkp_busy[k] combinational = busy_q[idx] & (wrap_q[idx]==lkp wrap bit).
REQ-031 SHALL, when BYPASS=1, additionally force lkp_busy[k]=0 when a same-cycle non-abort completion matches that itag; with BYPASS=0 there is no bypass and results reflect state only.
REQ-032 SHALL make lkp_busy ignore set, abort, zap and flush in the same cycle; those affect the next cycle only.
REQ-033 SHALL register busy_cnt as the popcount of next-state busy, so it is valid one cycle after the update.
REQ-034 SHALL set err_dup when set_v[p] hits a slot with busy_q=1 that is not cleared in the same cycle, or when two set ports target the same index; err_dup holds until rst.
REQ-035 SHALL OR duplicate matches across ports; multiple clears of one slot are legal.
REQ-036 SHALL, when act=0, hold busy_q, wrap_q, busy_cnt and err_dup; lkp_busy remains combinational.

Reset
REQ-037 SHALL, on rst, set busy_q=0, wrap_q=0, busy_cnt=0, empty=1 and err_dup=0 on the next edge, overriding act.
REQ-038 SHALL, on rst asserted mid-operation, discard all same-cycle set, clear and flush requests.

Verification
REQ-039 SHALL be verified with: set itag 5 -> next cycle lkp 5 busy=1, busy_cnt=1; clr 5 -> lkp 5 busy=0 same cycle (BYPASS=1), busy_cnt=0 the next cycle.
REQ-040 SHALL be verified with: set 0x21 (wrap1, idx1), then lkp 0x01 -> busy=0 and lkp 0x21 -> busy=1.
REQ-041 SHALL be verified with: busy 30, 31, 0x20, 0x21 (wrap across the top), flush_itag 31 -> 31, 0x20 and 0x21 cleared; 30 stays busy; busy_cnt=1.
REQ-042 SHALL be verified with: completion with abort on busy slot 7 -> slot 7 stays busy; abort on idle slot 9 -> slot 9 becomes busy.
REQ-043 SHALL be verified with: set 3 twice without a clear -> err_dup=1, which persists until rst.
REQ-044 SHALL be verified with: 32 slots busy, then zap together with set 4 -> all slots clear, empty=1 the next cycle.
